// File: rtl/uart_transceiver.sv
// -----------------------------------------------------------------------------
// uart_transceiver
//   Full-duplex UART with independent receiver and transmitter.
//   Frame: 1 start bit (0), PAYLOAD_BITS data bits LSB first, STOP_BITS stop
//   bits (1), no parity. Bit period is CLK_HZ/BIT_RATE CLK cycles (truncated).
//
// Ports
//   CLK            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   uart_rxd       in   serial receive line (asynchronous, idle high)
//   uart_rx_en     in   receiver enable (a frame already started is finished)
//   uart_rx_break  out  one-cycle pulse: all-zero frame with a low stop bit
//   uart_rx_valid  out  one-cycle pulse: uart_rx_data holds a new payload
//   uart_rx_data   out  last good payload, held until the next good frame
//   uart_tx_en     in   transmit request, honoured only while not busy
//   uart_tx_data   in   payload to transmit, latched on an accepted request
//   uart_txd       out  serial transmit line (registered, idle high)
//   uart_tx_busy   out  transmitter occupied with a frame
//
// Receiver / transmitter states
//   state | meaning
//   IDLE  | waiting (RX: for a start edge, TX: for a request)
//   START | RX: waiting for mid-start-bit sample, TX: driving start bit
//   DATA  | shifting payload bits, LSB first
//   STOP  | RX: waiting for mid-stop-bit sample, TX: driving stop bit(s)
// -----------------------------------------------------------------------------
module uart_transceiver #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_txd,
  output logic                    uart_tx_busy
);

  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int CNT_W    = $clog2(STOP_CYC + 1);
  localparam int IDX_W    = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CNT_W-1:0] CPB_M1   = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] STOP_M1  = CNT_W'(STOP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  state_t                  rx_state_q;
  logic                    rxd_s1_q;
  logic                    rxd_s2_q;
  logic                    rxd_prev_q;
  logic [CNT_W-1:0]        rx_cnt_q;
  logic [IDX_W-1:0]        rx_idx_q;
  logic [PAYLOAD_BITS-1:0] rx_shift_q;
  logic [PAYLOAD_BITS-1:0] rx_shift_d;
  logic [PAYLOAD_BITS-1:0] rx_data_q;
  logic                    rx_valid_q;
  logic                    rx_break_q;
  logic                    rx_fall;

  // A start needs a 1 followed by a 0 on the synchronized line, so after a
  // break (line stuck low) no new frame begins until the line has gone high.
  assign rx_fall = rxd_prev_q & ~rxd_s2_q;

  // Shift the centre sample in at the MSB end; after PAYLOAD_BITS samples
  // the first (LSB) bit has reached bit 0.
  always_comb begin
    rx_shift_d                   = rx_shift_q >> 1;
    rx_shift_d[PAYLOAD_BITS-1]   = rxd_s2_q;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rx_state_q <= IDLE;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_break_q <= 1'b0;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_valid_q <= 1'b0;
      rx_break_q <= 1'b0;

      case (rx_state_q)
        IDLE: begin
          rx_cnt_q <= '0;
          rx_idx_q <= '0;
          if (uart_rx_en && rx_fall) begin
            rx_state_q <= START;
          end
        end

        START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q <= '0;
            // Line back high at mid-start: treat as a glitch.
            rx_state_q <= rxd_s2_q ? IDLE : DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (rx_cnt_q == CPB_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= rx_shift_d;
            if (rx_idx_q == LAST_IDX) begin
              rx_idx_q   <= '0;
              rx_state_q <= STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (rx_cnt_q == CPB_M1) begin
            rx_cnt_q   <= '0;
            rx_state_q <= IDLE;
            if (rxd_s2_q) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else if (rx_shift_q == '0) begin
              rx_break_q <= 1'b1;
            end
            // Low stop with non-zero data: framing error, frame dropped.
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end

        default: rx_state_q <= IDLE;
      endcase
    end
  end

  assign uart_rx_valid = rx_valid_q;
  assign uart_rx_break = rx_break_q;
  assign uart_rx_data  = rx_data_q;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t                  tx_state_q;
  logic [CNT_W-1:0]        tx_cnt_q;
  logic [IDX_W-1:0]        tx_idx_q;
  logic [PAYLOAD_BITS-1:0] tx_shift_q;
  logic                    txd_q;
  logic                    tx_busy_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        IDLE: begin
          tx_cnt_q <= '0;
          tx_idx_q <= '0;
          txd_q    <= 1'b1;
          if (uart_tx_en) begin
            tx_shift_q <= uart_tx_data;
            tx_state_q <= START;
            txd_q      <= 1'b0;
            tx_busy_q  <= 1'b1;
          end
        end

        START: begin
          if (tx_cnt_q == CPB_M1) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_state_q <= DATA;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tx_cnt_q == CPB_M1) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == LAST_IDX) begin
              tx_idx_q   <= '0;
              tx_state_q <= STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_idx_q   <= tx_idx_q + 1'b1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end

        STOP: begin
          txd_q <= 1'b1;
          if (tx_cnt_q == STOP_M1) begin
            tx_cnt_q   <= '0;
            tx_state_q <= IDLE;
            tx_busy_q  <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end

        default: tx_state_q <= IDLE;
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at CPB = 10 (1 MHz clock, 100 kbit/s).
module tb_uart_transceiver;

  logic       CLK;
  logic       reset;
  logic       rxd_drv;
  logic       loop_en;
  logic       rxd_w;
  logic       uart_rx_en;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_txd;
  logic       uart_tx_busy;

  int passed = 0;
  int total  = 0;
  int valid_cnt = 0;
  int break_cnt = 0;
  logic [7:0] last_rx = 8'h00;

  assign rxd_w = loop_en ? uart_txd : rxd_drv;

  uart_transceiver #(
    .BIT_RATE    (100_000),
    .CLK_HZ      (1_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .uart_rxd     (rxd_w),
    .uart_rx_en   (uart_rx_en),
    .uart_rx_break(uart_rx_break),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data (uart_rx_data),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse monitor: counts high cycles of each strobe.
  always @(negedge CLK) begin
    if (uart_rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_rx   <= uart_rx_data;
    end
    if (uart_rx_break) break_cnt <= break_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Issue a one-cycle request; returns 1 ns after the capturing edge.
  task automatic tx_req(input logic [7:0] d);
    uart_tx_en   = 1'b1;
    uart_tx_data = d;
    cyc(1);
    uart_tx_en   = 1'b0;
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input logic stop_bit);
    rxd_drv = 1'b0;
    cyc(10);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      cyc(10);
    end
    rxd_drv = stop_bit;
    cyc(10);
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(3);
    total++;
    if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || uart_rx_valid !== 1'b0 ||
        uart_rx_break !== 1'b0 || uart_rx_data !== 8'h00)
      $display("FAIL reset_outputs: txd=%b busy=%b valid=%b break=%b data=%h, want 1 0 0 0 00",
               uart_txd, uart_tx_busy, uart_rx_valid, uart_rx_break, uart_rx_data);
    else passed++;
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_tx_a5;
    logic [9:0] exp_bits;
    int bad;
    exp_bits = 10'b1101001010;   // stop,d7..d0,start for 0xA5
    bad = 0;
    tx_req(8'hA5);
    total++;
    if (uart_tx_busy !== 1'b1 || uart_txd !== 1'b0)
      $display("FAIL tx_first_cycle: busy=%b txd=%b, want 1 0", uart_tx_busy, uart_txd);
    else passed++;
    for (int k = 0; k < 100; k++) begin
      if (uart_txd !== exp_bits[k/10] || uart_tx_busy !== 1'b1) bad++;
      cyc(1);
    end
    total++;
    if (bad != 0) $display("FAIL tx_a5_waveform: %0d bad cycles, want 0", bad);
    else passed++;
    total++;
    if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1)
      $display("FAIL tx_busy_fall: busy=%b txd=%b after 100 cycles, want 0 1", uart_tx_busy, uart_txd);
    else passed++;
    cyc(5);
  endtask

  task automatic test_loopback;
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    loop_en = 1'b1;
    tx_req(8'h3C);
    cyc(110);
    total++;
    if (valid_cnt - v0 != 1 || last_rx !== 8'h3C)
      $display("FAIL loopback_3c: pulses=%0d data=%h, want 1 3c", valid_cnt - v0, last_rx);
    else passed++;
    total++;
    if (break_cnt != b0) $display("FAIL loopback_break: breaks=%0d, want 0", break_cnt - b0);
    else passed++;
    loop_en = 1'b0;
    cyc(5);
  endtask

  task automatic test_break;
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    rxd_drv = 1'b0;
    cyc(120);
    rxd_drv = 1'b1;
    cyc(30);
    total++;
    if (break_cnt - b0 != 1) $display("FAIL break_pulse: breaks=%0d, want 1", break_cnt - b0);
    else passed++;
    total++;
    if (valid_cnt != v0 || uart_rx_data !== 8'h3C)
      $display("FAIL break_data: valids=%0d data=%h, want 0 3c", valid_cnt - v0, uart_rx_data);
    else passed++;
  endtask

  task automatic test_glitch;
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    rxd_drv = 1'b0;
    cyc(3);
    rxd_drv = 1'b1;
    cyc(30);
    total++;
    if (valid_cnt != v0 || break_cnt != b0)
      $display("FAIL glitch_ignored: valids=%0d breaks=%0d, want 0 0", valid_cnt - v0, break_cnt - b0);
    else passed++;
    drive_rx_frame(8'h55, 1'b1);
    cyc(10);
    total++;
    if (valid_cnt - v0 != 1 || uart_rx_data !== 8'h55)
      $display("FAIL glitch_then_55: valids=%0d data=%h, want 1 55", valid_cnt - v0, uart_rx_data);
    else passed++;
  endtask

  task automatic test_framing_error;
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    drive_rx_frame(8'h81, 1'b0);
    cyc(20);
    total++;
    if (valid_cnt != v0 || break_cnt != b0 || uart_rx_data !== 8'h55)
      $display("FAIL framing_error: valids=%0d breaks=%0d data=%h, want 0 0 55",
               valid_cnt - v0, break_cnt - b0, uart_rx_data);
    else passed++;
  endtask

  task automatic test_rx_enable;
    int v0;
    v0 = valid_cnt;
    loop_en = 1'b1;
    tx_req(8'h99);
    cyc(30);
    uart_rx_en = 1'b0;   // frame already under way must still complete
    cyc(90);
    total++;
    if (valid_cnt - v0 != 1 || uart_rx_data !== 8'h99)
      $display("FAIL rx_en_drop_midframe: valids=%0d data=%h, want 1 99", valid_cnt - v0, uart_rx_data);
    else passed++;
    v0 = valid_cnt;
    tx_req(8'h24);
    cyc(120);
    total++;
    if (valid_cnt != v0 || uart_rx_data !== 8'h99)
      $display("FAIL rx_disabled: valids=%0d data=%h, want 0 99", valid_cnt - v0, uart_rx_data);
    else passed++;
    uart_rx_en = 1'b1;
    loop_en = 1'b0;
    cyc(5);
  endtask

  task automatic test_back_to_back;
    int v0, bad;
    v0 = valid_cnt;
    bad = 0;
    loop_en = 1'b1;
    tx_req(8'h00);
    for (int k = 0; k < 100; k++) begin
      if (k == 30) begin uart_tx_en = 1'b1; uart_tx_data = 8'hFF; end
      if (k == 31) uart_tx_en = 1'b0;
      if (uart_txd !== ((k >= 90) ? 1'b1 : 1'b0)) bad++;
      cyc(1);
    end
    total++;
    if (bad != 0) $display("FAIL ignore_busy_req: %0d bad txd cycles, want 0", bad);
    else passed++;
    total++;
    if (uart_tx_busy !== 1'b0) $display("FAIL b2b_busy_low: busy=%b, want 0", uart_tx_busy);
    else passed++;
    tx_req(8'h96);
    total++;
    if (uart_tx_busy !== 1'b1 || uart_txd !== 1'b0)
      $display("FAIL b2b_start: busy=%b txd=%b, want 1 0", uart_tx_busy, uart_txd);
    else passed++;
    cyc(110);
    total++;
    if (valid_cnt - v0 != 2 || last_rx !== 8'h96)
      $display("FAIL b2b_rx: valids=%0d data=%h, want 2 96", valid_cnt - v0, last_rx);
    else passed++;
    loop_en = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset_midframe;
    int v0, b0;
    loop_en = 1'b1;
    tx_req(8'h3C);
    cyc(45);
    v0 = valid_cnt; b0 = break_cnt;
    reset = 1'b1;
    #1;
    total++;
    if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || uart_rx_data !== 8'h00)
      $display("FAIL reset_midframe: txd=%b busy=%b data=%h, want 1 0 00",
               uart_txd, uart_tx_busy, uart_rx_data);
    else passed++;
    cyc(3);
    reset = 1'b0;
    cyc(120);
    total++;
    if (valid_cnt != v0 || break_cnt != b0)
      $display("FAIL reset_no_pulse: valids=%0d breaks=%0d, want 0 0", valid_cnt - v0, break_cnt - b0);
    else passed++;
    tx_req(8'hC3);
    cyc(110);
    total++;
    if (valid_cnt - v0 != 1 || uart_rx_data !== 8'hC3)
      $display("FAIL after_reset_frame: valids=%0d data=%h, want 1 c3", valid_cnt - v0, uart_rx_data);
    else passed++;
    loop_en = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    rxd_drv      = 1'b1;
    loop_en      = 1'b0;
    uart_rx_en   = 1'b1;
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;
    #1;
    test_reset();
    test_tx_a5();
    test_loopback();
    test_break();
    test_glitch();
    test_framing_error();
    test_rx_enable();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 The block SHALL have parameter BIT_RATE, default 9600, meaning line bit rate in bits/s.
REQ-002 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning CLK frequency in Hz.
REQ-003 The block SHALL have parameter PAYLOAD_BITS, default 8, meaning data bits per frame.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per transmitted frame.
REQ-005 The block SHALL have port CLK, input, 1 bit: system clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port uart_rxd, input, 1 bit: serial receive line, asynchronous, idle high.
REQ-008 The block SHALL have port uart_rx_en, input, 1 bit: receiver enable.
REQ-009 The block SHALL have port uart_rx_break, output, 1 bit: one-cycle break-detected pulse.
REQ-010 The block SHALL have port uart_rx_valid, output, 1 bit: one-cycle received-byte-valid pulse.
REQ-011 The block SHALL have port uart_rx_data, output, PAYLOAD_BITS bits: last received payload.
REQ-012 The block SHALL have port uart_tx_en, input, 1 bit: transmit request.
REQ-013 The block SHALL have port uart_tx_data, input, PAYLOAD_BITS bits: payload to transmit.
REQ-014 The block SHALL have port uart_txd, output, 1 bit: serial transmit line, idle high.
REQ-015 The block SHALL have port uart_tx_busy, output, 1 bit: transmitter occupied.

Function
REQ-016 Frame format SHALL be: 1 start bit (0), PAYLOAD_BITS data bits LSB first, stop bit(s) (1), no parity.
REQ-017 Bit period SHALL be CPB = CLK_HZ/BIT_RATE CLK cycles, integer truncation (5208 at defaults).
REQ-018 Receiver SHALL pass uart_rxd through a 2-flop synchronizer (reset value 1) before use.
REQ-019 Receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-020 In IDLE with uart_rx_en=1, a synchronized falling edge (1->0) SHALL move the FSM to START.
REQ-021 In START, the line SHALL be sampled at CPB/2.
REQ-022 If the START sample is 1, the event is a glitch: the FSM SHALL return to IDLE with no output.
REQ-023 Otherwise, each data bit SHALL be sampled once per CPB, at its centre, and shifted in LSB first.
REQ-024 After the last data bit, the stop bit SHALL be sampled at its centre.
REQ-025 Stop sample 1: uart_rx_data SHALL update and uart_rx_valid SHALL pulse high for exactly one cycle.
REQ-026 Stop sample 0 with all data bits 0: uart_rx_break SHALL pulse one cycle, uart_rx_valid SHALL stay 0, and uart_rx_data SHALL be unchanged.
REQ-027 Stop sample 0 with non-zero data (framing error): the frame SHALL be discarded with no pulses.
REQ-028 After STOP, the receiver SHALL return to IDLE and SHALL NOT detect a new start until the line has been seen high.
REQ-029 uart_rx_data SHALL hold its value until the next valid frame.
REQ-030 uart_rx_en=0 SHALL hold the receiver in IDLE; a frame already in progress SHALL be completed.
REQ-031 Transmitter FSM SHALL have states IDLE, START, DATA, STOP.
REQ-032 uart_tx_en=1 while uart_tx_busy=0 SHALL latch uart_tx_data, and uart_tx_busy SHALL go high the next cycle.
REQ-033 On that same next cycle, uart_txd SHALL drive the start bit.
REQ-034 uart_tx_en while uart_tx_busy=1 SHALL be ignored, and the latched data SHALL be unaffected.
REQ-035 Each transmitted bit SHALL last exactly CPB cycles; the stop phase SHALL last STOP_BITS*CPB cycles.
REQ-036 uart_tx_busy SHALL fall in the cycle after the stop phase ends.
REQ-037 A new request SHALL be accepted in the first cycle uart_tx_busy=0, giving back-to-back frames with no idle gap.
REQ-038 uart_txd SHALL be registered (glitch-free) and SHALL be 1 whenever the transmitter is not sending start or data bits.
REQ-039 Receiver and transmitter SHALL operate fully independently; simultaneous RX and TX activity is legal.

Reset
REQ-040 While reset=1, outputs SHALL be: uart_txd=1, uart_tx_busy=0, uart_rx_valid=0, uart_rx_break=0, uart_rx_data=0.
REQ-041 While reset=1, both FSMs SHALL be in IDLE and all counters and shift registers SHALL be 0.
REQ-042 Reset asserted mid-frame SHALL abort both FSMs immediately, with no pulse emitted for the aborted frame.
REQ-043 After reset deasserts, the first CLK edge SHALL be normal operation.

Verification
REQ-044 Scenario: CLK_HZ=1_000_000, BIT_RATE=100_000 (CPB=10); pulse uart_tx_en with 0xA5 -> busy high the next cycle; uart_txd = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; busy low 100 cycles after it rose.
REQ-045 Scenario: loop uart_txd to uart_rxd, rx_en=1, send 0x3C -> one uart_rx_valid pulse with uart_rx_data=0x3C, uart_rx_break never high.
REQ-046 Scenario: drive uart_rxd low for 12 bit periods -> one uart_rx_break pulse, no uart_rx_valid, uart_rx_data unchanged.
REQ-047 Scenario: 3-cycle low glitch on idle uart_rxd -> no valid or break pulse; a following frame 0x55 is received correctly.
REQ-048 Scenario: second uart_tx_en (0xFF) pulsed mid-frame of 0x00 -> ignored, only 0x00 is sent; a request on the first non-busy cycle starts a frame back-to-back.
REQ-049 Scenario: assert reset mid-TX and mid-RX -> txd=1, busy=0, no valid pulse; the next frame after reset completes correctly.
